risc_mem_arbiter: RTL and testbench
===================================

Name: risc_mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the pipelined RISC core between three requesters.
- Requesters: the loader/debug port (program preload while halted), the MEM-stage data port (LW/SW) and the IF-stage fetch port.
- Serialises transactions to one memory request/acknowledge interface, bounds fetch starvation and aborts hung transfers with a timeout.

Parameters:
- AW, 10, memory word-address width
- DW, 32, data width
- MAX_WAIT, 4, consecutive lost arbitrations after which fetch beats data
- TIMEOUT, 16, cycles to wait for m_ack before aborting

Ports:
- clk1 input 1 single system clock, rising edge
- rst input 1 asynchronous active-high reset
- halted input 1 core HALTED flag; loader port only eligible when 1
- ld_req input 1 loader request
- ld_we input 1 loader write enable
- ld_addr input AW loader address
- ld_wdata input DW loader write data
- dt_req / dt_we / dt_addr / dt_wdata: same set for the data port
- if_req / if_addr: fetch port, read-only
- ld_done / dt_done / if_done output 1 one-cycle completion pulse per requester
- rdata output DW read data, valid with any done pulse
- err output 1 valid with done; 1 means the transaction timed out
- m_req output 1 memory request, held until m_ack or abort
- m_we output 1 memory write enable
- m_addr output AW memory address
- m_wdata output DW memory write data
- m_rdata input DW memory read data, valid with m_ack
- m_ack input 1 memory acknowledge, one cycle

Behaviour:
- Reset (async): state=IDLE, owner=NONE. All outputs 0: m_req, m_we, m_addr, m_wdata, all done pulses, rdata, err. Wait and timeout counters 0.
- States: IDLE, ACCESS, DONE.
- IDLE: arbitration is evaluated at each rising edge.
  - Priority: loader (only if halted=1), then data, then fetch.
  - Exception: if fetch_wait==MAX_WAIT and if_req=1, fetch beats data. Fetch never beats an eligible loader.
  - Winner's we/addr/wdata are latched into m_*. m_req=1 from the next cycle; go to ACCESS.
  - Fetch always sets m_we=0.
- fetch_wait counter:
  - Increments (saturating at MAX_WAIT) at each IDLE arbitration where if_req=1 and data wins.
  - Clears when fetch is granted or if_req=0.
  - Loader wins do not change it.
- ACCESS:
  - m_* are held stable.
  - On m_ack=1: rdata<=m_rdata (write transactions also update rdata), err<=0, m_req<=0, go to DONE.
  - If TIMEOUT cycles pass with no m_ack: m_req<=0, rdata<=0, err<=1, go to DONE.
- DONE:
  - The owner's done is 1 for exactly one cycle, then return to IDLE.
  - The IDLE arbitration edge therefore follows the DONE cycle. A requester that keeps req high during its done cycle is treated as issuing a new transaction.
- Minimum transaction with immediate ack: grant edge N, m_req high in cycle N+1, m_ack in N+1, done in cycle N+2, next grant edge N+3.
- Requesters hold req/we/addr/wdata stable from assertion until their done. Changes after grant are ignored; values are latched.
- m_ack while in IDLE or DONE is ignored. A late ack after a timeout is therefore discarded.
- halted falling while a loader transaction is in ACCESS: the transaction completes normally. Eligibility is checked only at arbitration.
- rst asserted mid-ACCESS: immediate return to reset state, no done pulse issued, and any subsequent m_ack is ignored.
- The timeout counter is a $clog2(TIMEOUT+1)-bit counter and clears on every grant.

Decomposition:
- Package risc_pkg holds:
  - owner_t enum: OWN_NONE, OWN_LD, OWN_DT, OWN_IF
  - arb_state_t enum: IDLE, ACCESS, DONE
  - localparam defaults for AW and DW shared with the core
- Sub-module risc_prio_sel is natural:
  - Combinational, takes ld_req&halted, dt_req, if_req, fetch_boost.
  - Returns owner_t.
  - Verified separately.

Test Plan:
- Write then read loader port: halted=1; ld write addr 5 data 0x2801000a; then ld read addr 5. Expect ld_done twice, rdata=0x2801000a, err=0, no dt/if done.
- Data vs fetch contention: dt_req and if_req both held continuously, ack latency 0, MAX_WAIT=4. Expect grant order D,D,D,D,F,D,D,D,D,F…, and fetch completes at least once in every 5 transactions.
- Loader gating: halted=0 with ld_req=1 and if_req=1. Expect only if_done. Set halted=1 and the next arbitration grants the loader ahead of data.
- Timeout: dt read with m_ack never asserted. Expect m_req high for exactly 16 cycles, then dt_done=1 with err=1 and rdata=0. An ack injected 2 cycles later changes nothing.
- Reset mid-access: assert rst during ACCESS of a fetch to addr 3. Expect m_req=0 immediately and no if_done. After release, a fresh if_req to addr 3 completes with the correct data.
- Back-to-back: fetch addr 0..8 with if_req held, ack delay 2. Expect 9 if_done pulses spaced 5 cycles apart (3 ACCESS + DONE + grant edge) and rdata matching memory contents in order.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and widths for the RISC memory arbiter
package risc_pkg;

    localparam int RISC_AW = 10;
    localparam int RISC_DW = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_LD,
        OWN_DT,
        OWN_IF
    } owner_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

endpackage

// File: rtl/risc_prio_sel.sv
// rtl/risc_prio_sel.sv - fixed-priority requester select with fetch anti-starvation boost
module risc_prio_sel
    import risc_pkg::*;
(
    input  logic   ld_ok,
    input  logic   dt_req,
    input  logic   if_req,
    input  logic   fetch_boost,
    output owner_t winner
);

    // A boosted fetch jumps ahead of data but never ahead of an eligible loader.
    always_comb begin
        winner = OWN_NONE;
        if (ld_ok) begin
            winner = OWN_LD;
        end else if (fetch_boost) begin
            winner = OWN_IF;
        end else if (dt_req) begin
            winner = OWN_DT;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/risc_mem_arbiter.sv
// rtl/risc_mem_arbiter.sv - serialises loader, data and fetch ports onto one memory req/ack interface
module risc_mem_arbiter
    import risc_pkg::*;
#(
    parameter int AW       = RISC_AW,
    parameter int DW       = RISC_DW,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          halted,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          dt_req,
    input  logic          dt_we,
    input  logic [AW-1:0] dt_addr,
    input  logic [DW-1:0] dt_wdata,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          ld_done,
    output logic          dt_done,
    output logic          if_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(MAX_WAIT + 1);

    arb_state_t    state;
    owner_t        owner;
    owner_t        winner;
    logic [TW-1:0] tcnt;
    logic [FW-1:0] fetch_wait;
    logic          fetch_boost;
    logic          expired;
    logic          xfer_end;

    assign fetch_boost = if_req && (fetch_wait == FW'(MAX_WAIT));
    assign expired     = (tcnt == TW'(TIMEOUT - 1));
    assign xfer_end    = (state == ACCESS) && (m_ack || expired);

    risc_prio_sel u_prio_sel (
        .ld_ok       (ld_req & halted),
        .dt_req      (dt_req),
        .if_req      (if_req),
        .fetch_boost (fetch_boost),
        .winner      (winner)
    );

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            tcnt       <= '0;
            fetch_wait <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            ld_done    <= 1'b0;
            dt_done    <= 1'b0;
            if_done    <= 1'b0;
        end else begin
            ld_done <= xfer_end && (owner == OWN_LD);
            dt_done <= xfer_end && (owner == OWN_DT);
            if_done <= xfer_end && (owner == OWN_IF);
            case (state)
                IDLE: begin
                    if (!if_req || winner == OWN_IF) begin
                        fetch_wait <= '0;
                    end else if (winner == OWN_DT && fetch_wait != FW'(MAX_WAIT)) begin
                        fetch_wait <= fetch_wait + 1'b1;
                    end
                    owner <= winner;
                    tcnt  <= '0;
                    case (winner)
                        OWN_LD: begin
                            m_req   <= 1'b1;
                            m_we    <= ld_we;
                            m_addr  <= ld_addr;
                            m_wdata <= ld_wdata;
                        end
                        OWN_DT: begin
                            m_req   <= 1'b1;
                            m_we    <= dt_we;
                            m_addr  <= dt_addr;
                            m_wdata <= dt_wdata;
                        end
                        OWN_IF: begin
                            m_req   <= 1'b1;
                            m_we    <= 1'b0;
                            m_addr  <= if_addr;
                            m_wdata <= '0;
                        end
                        default: ;
                    endcase
                    if (winner != OWN_NONE) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // An ack on the final timeout cycle still counts as a success.
                    if (m_ack) begin
                        rdata <= m_rdata;
                        err   <= 1'b0;
                        m_req <= 1'b0;
                        state <= DONE;
                    end else if (expired) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        m_req <= 1'b0;
                        state <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// tb/tb_risc_mem_arbiter.sv - directed table-driven bench for risc_mem_arbiter with a memory responder
module tb_risc_mem_arbiter;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        halted = 1'b0;
    logic        ld_req = 1'b0, ld_we = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_wdata = '0;
    logic        dt_req = 1'b0, dt_we = 1'b0;
    logic [9:0]  dt_addr = '0;
    logic [31:0] dt_wdata = '0;
    logic        if_req = 1'b0;
    logic [9:0]  if_addr = '0;
    logic        ld_done, dt_done, if_done;
    logic [31:0] rdata;
    logic        err;
    logic        m_req, m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    risc_mem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(4), .TIMEOUT(16)) dut (
        .clk1(clk1), .rst(rst), .halted(halted),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
        .if_req(if_req), .if_addr(if_addr),
        .ld_done(ld_done), .dt_done(dt_done), .if_done(if_done),
        .rdata(rdata), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk1 = ~clk1;

    // Memory responder: acks after ack_delay extra cycles of m_req.
    logic [31:0] mem [0:1023];
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    logic        inject_ack = 1'b0;
    int          acc_cnt = 0;
    int          cyc = 0;

    always @(posedge clk1) begin
        cyc++;
        #1;
        m_ack = 1'b0;
        if (rst || !m_req) begin
            acc_cnt = 0;
        end else begin
            if (ack_en && acc_cnt == ack_delay) begin
                m_ack = 1'b1;
                if (m_we) begin
                    mem[m_addr] = m_wdata;
                    m_rdata = m_wdata;
                end else begin
                    m_rdata = mem[m_addr];
                end
            end
            acc_cnt++;
        end
        if (inject_ack) begin
            m_ack = 1'b1;
            m_rdata = 32'hDEAD_BEEF;
            inject_ack = 1'b0;
        end
    end

    int order[$];
    int if_cnt = 0;
    always @(negedge clk1) begin
        if (ld_done) order.push_back(1);
        if (dt_done) order.push_back(2);
        if (if_done) begin
            order.push_back(3);
            if_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output logic [2:0] mask, output logic [31:0] rd, output logic e);
        mask = '0;
        rd = '0;
        e = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk1);
            if (ld_done || dt_done || if_done) begin
                mask = {ld_done, dt_done, if_done};
                rd = rdata;
                e = err;
                break;
            end
        end
        ld_req = 1'b0;
        dt_req = 1'b0;
        if_req = 1'b0;
        if (mask == 3'b000) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_done: no done pulse within 100 cycles");
        end
    endtask

    typedef struct {
        logic        halted;
        logic        ld;
        logic        dt;
        logic        fi;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic [2:0]  exp_mask;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [2:0]  mask;
        logic [31:0] rd;
        logic        e;
        int          mreq_cycles;
        int          last_cyc;
        int          if_before;
        logic [31:0] exp_rd;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;

        //        halt  ld    dt    fi    we    addr   wdata          dly mask    rdata
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd5, 32'h2801_000A, 0, 3'b100, 32'h2801_000A};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd5, 32'h0,         0, 3'b100, 32'h2801_000A};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd7, 32'h0,         1, 3'b010, 32'hA000_0007};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd9, 32'h1234_5678, 3, 3'b010, 32'h1234_5678};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd9, 32'h0,         0, 3'b001, 32'h1234_5678};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd5, 32'h0,         0, 3'b100, 32'h2801_000A};
        vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd2, 32'h0,         2, 3'b010, 32'hA000_0002};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd4, 32'h0,         0, 3'b001, 32'hA000_0004};
        vt[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd6, 32'h0,         0, 3'b010, 32'hA000_0006};

        repeat (2) @(negedge clk1);
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_m_we", {31'd0, m_we}, 32'd0);
        check("rst_m_addr", {22'd0, m_addr}, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err_done", {28'd0, err, ld_done, dt_done, if_done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk1);

        for (int i = 0; i < 9; i++) begin
            halted = vt[i].halted;
            ld_req = vt[i].ld;  ld_we = vt[i].we; ld_addr = vt[i].addr; ld_wdata = vt[i].wdata;
            dt_req = vt[i].dt;  dt_we = vt[i].we; dt_addr = vt[i].addr; dt_wdata = vt[i].wdata;
            if_req = vt[i].fi;  if_addr = vt[i].addr;
            ack_delay = vt[i].delay;
            wait_done(mask, rd, e);
            check($sformatf("vec%0d_owner", i), {29'd0, mask}, {29'd0, vt[i].exp_mask});
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'd0, e}, 32'd0);
            repeat (2) @(negedge clk1);
        end

        // Data and fetch both held: every fifth grant must go to fetch.
        ack_delay = 0;
        order.delete();
        dt_req = 1'b1; dt_we = 1'b0; dt_addr = 10'd1;
        if_req = 1'b1; if_addr = 10'd2;
        for (int k = 0; k < 300 && order.size() < 15; k++) @(negedge clk1);
        dt_req = 1'b0;
        if_req = 1'b0;
        if (order.size() < 15) begin
            n_vec++;
            n_err++;
            $display("FAIL contention: only %0d completions, expected 15", order.size());
        end else begin
            for (int i = 0; i < 15; i++)
                check($sformatf("contention_grant%0d", i), order[i], (i % 5 == 4) ? 3 : 2);
        end
        repeat (10) @(negedge clk1);

        // Timeout with no ack, then a stray late ack.
        ack_en = 1'b0;
        halted = 1'b0;
        dt_req = 1'b1; dt_we = 1'b0; dt_addr = 10'd3;
        mreq_cycles = 0;
        mask = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk1);
            if (m_req) mreq_cycles++;
            if (ld_done || dt_done || if_done) begin
                mask = {ld_done, dt_done, if_done};
                break;
            end
        end
        dt_req = 1'b0;
        check("timeout_mreq_cycles", mreq_cycles, 16);
        check("timeout_owner", {29'd0, mask}, 32'b010);
        check("timeout_err", {31'd0, err}, 32'd1);
        check("timeout_rdata", rdata, 32'd0);
        @(negedge clk1);
        inject_ack = 1'b1;
        order.delete();
        repeat (6) @(negedge clk1);
        check("late_ack_no_done", order.size(), 0);
        check("late_ack_err_held", {31'd0, err}, 32'd1);
        check("late_ack_rdata_held", rdata, 32'd0);
        check("late_ack_no_req", {31'd0, m_req}, 32'd0);

        // Reset during a fetch access.
        if_req = 1'b1; if_addr = 10'd3;
        for (int k = 0; k < 20 && !m_req; k++) @(negedge clk1);
        check("rstmid_in_access", {31'd0, m_req}, 32'd1);
        if_before = if_cnt;
        rst = 1'b1;
        #1;
        check("rstmid_m_req_drop", {31'd0, m_req}, 32'd0);
        check("rstmid_m_addr", {22'd0, m_addr}, 32'd0);
        if_req = 1'b0;
        repeat (3) @(negedge clk1);
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (3) @(negedge clk1);
        check("rstmid_no_done", if_cnt, if_before);
        if_req = 1'b1; if_addr = 10'd3;
        wait_done(mask, rd, e);
        check("rstmid_refetch_owner", {29'd0, mask}, 32'b001);
        check("rstmid_refetch_rdata", rd, 32'hA000_0003);
        repeat (3) @(negedge clk1);

        // Back-to-back fetches with ack delay 2: done every 5 cycles.
        ack_delay = 2;
        if_req = 1'b1;
        if_addr = 10'd0;
        last_cyc = 0;
        for (int i = 0; i < 9; i++) begin
            mask = '0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk1);
                if (if_done) begin
                    mask = 3'b001;
                    break;
                end
            end
            exp_rd = (i == 5) ? 32'h2801_000A : 32'hA000_0000 + i;
            if (mask != 3'b001) begin
                n_vec++;
                n_err++;
                $display("FAIL b2b%0d: no if_done within 40 cycles", i);
            end else begin
                check($sformatf("b2b%0d_rdata", i), rdata, exp_rd);
                if (i > 0) check($sformatf("b2b%0d_spacing", i), cyc - last_cyc, 5);
            end
            last_cyc = cyc;
            if_addr = 10'(i + 1);
        end
        if_req = 1'b0;
        repeat (5) @(negedge clk1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
